// File: rtl/ipi_delivery_scheduler_pkg.sv
// Shared types for the IPI delivery scheduler.
//   core_id_t          : core identifier on the ring
//   ring_packet        : packet as presented by the ring stop
//   ipi_entry_t        : what is queued per IPI (sender + reason word)
//   ipi_state_e        : delivery FSM state, exported for debug
package ipi_delivery_scheduler_pkg;

  localparam int NUM_CORES = 8;
  localparam int CORE_ID_W = $clog2(NUM_CORES);

  typedef logic [CORE_ID_W-1:0] core_id_t;

  typedef enum logic [1:0] {
    RING_PACKET_KIND_NONE  = 2'd0,
    RING_PACKET_KIND_IPI   = 2'd1,
    RING_PACKET_KIND_MSG   = 2'd2,
    RING_PACKET_KIND_FLUSH = 2'd3
  } ring_packet_kind_t;

  typedef struct packed {
    logic                  valid;
    ring_packet_kind_t     kind;
    core_id_t              sender_id;
    logic [NUM_CORES-1:0]  dest_vector;
    logic [31:0]           ipi_reason;
  } ring_packet;

  typedef struct packed {
    core_id_t    sender;
    logic [31:0] reason;
  } ipi_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } ipi_state_e;

endpackage

// File: rtl/ipi_delivery_scheduler_if.sv
// Bus bundle between ring stop / core (master side) and the scheduler (slave).
//   rx_issue, rx_packet -> packet offer from the ring stop
//   rx_ready            <- scheduler has room
//   ipi_interrupt_ack   -> core acknowledge (level)
//   ipi_interrupt_out, ipi_reason_out, ipi_issuer_out <- delivery to core
//
// Handshake: a packet transfers on a clk edge where rx_issue=1 and rx_ready=1.
// rx_ready depends only on registered occupancy, never on rx_issue. Issuing
// while rx_ready=0 is a protocol violation: the packet is dropped and counted.
// On the core side, ipi_interrupt_out stays high with a stable payload until
// the core raises ipi_interrupt_ack; the ack must fall again before the next
// IPI can be presented.
interface ipi_delivery_scheduler_if;
  import ipi_delivery_scheduler_pkg::*;

  logic        rx_issue;
  ring_packet  rx_packet;
  logic        rx_ready;
  logic        ipi_interrupt_ack;
  logic        ipi_interrupt_out;
  logic [31:0] ipi_reason_out;
  core_id_t    ipi_issuer_out;

  modport master (
    output rx_issue, rx_packet, ipi_interrupt_ack,
    input  rx_ready, ipi_interrupt_out, ipi_reason_out, ipi_issuer_out
  );

  modport slave (
    input  rx_issue, rx_packet, ipi_interrupt_ack,
    output rx_ready, ipi_interrupt_out, ipi_reason_out, ipi_issuer_out
  );
endinterface

// File: rtl/ipi_delivery_scheduler_fifo.sv
// Small FIFO of ipi_entry_t with a separate occupancy counter.
//   push/push_data : write at tail when not full
//   pop/pop_data   : pop_data is the head; pop advances when not empty
//   full/empty/count : derived from the count register
module ipi_delivery_scheduler_fifo
  import ipi_delivery_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  ipi_entry_t             push_data,
  input  logic                   pop,
  output ipi_entry_t             pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ipi_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/ipi_delivery_scheduler.sv
// IPI delivery scheduler: filters ring packets addressed to this core, queues
// them, and presents them to the core one at a time under interrupt/ack.
//   clk, reset    : clock, synchronous active-high reset
//   core_id       : this core's ID (static after reset)
//   bus (slave)   : ring-stop receive side and core interrupt side
//   pending_count : queued entries, excluding the one being presented
//   drop_count    : saturating count of packets issued while full
//   debug_state   : delivery FSM state
module ipi_delivery_scheduler
  import ipi_delivery_scheduler_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int MIN_GAP    = 1,
  parameter int DROP_CTR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  core_id_t                core_id,
  ipi_delivery_scheduler_if.slave bus,
  output logic [$clog2(DEPTH):0]  pending_count,
  output logic [DROP_CTR_W-1:0]   drop_count,
  output ipi_state_e              debug_state
);
  localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  ipi_state_e            state_q, state_d;
  logic                  int_q, int_d;
  logic [31:0]           reason_q, reason_d;
  core_id_t              issuer_q, issuer_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DROP_CTR_W-1:0] drop_q, drop_d;

  logic       accept;
  logic       fifo_pop, fifo_full, fifo_empty;
  ipi_entry_t fifo_head, fifo_in;

  assign accept = bus.rx_issue & bus.rx_packet.valid &
                  (bus.rx_packet.kind == RING_PACKET_KIND_IPI) &
                  bus.rx_packet.dest_vector[core_id];

  assign fifo_in.sender = bus.rx_packet.sender_id;
  assign fifo_in.reason = bus.rx_packet.ipi_reason;

  ipi_delivery_scheduler_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pending_count)
  );

  assign bus.rx_ready          = ~fifo_full;
  assign bus.ipi_interrupt_out = int_q;
  assign bus.ipi_reason_out    = reason_q;
  assign bus.ipi_issuer_out    = issuer_q;
  assign drop_count            = drop_q;
  assign debug_state           = state_q;

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    reason_d = reason_q;
    issuer_d = issuer_q;
    gap_d    = gap_q;
    drop_d   = drop_q;
    fifo_pop = 1'b0;

    if (accept && fifo_full && (drop_q != {DROP_CTR_W{1'b1}}))
      drop_d = drop_q + 1'b1;

    unique case (state_q)
      // IDLE sees only registered occupancy: a push this cycle is delivered
      // next cycle, there is no bypass.
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          reason_d = fifo_head.reason;
          issuer_d = fifo_head.sender;
          int_d    = 1'b1;
          state_d  = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (bus.ipi_interrupt_ack) begin
          int_d   = 1'b0;
          gap_d   = GAP_W'(MIN_GAP - 1);
          state_d = ST_GAP;
        end
      end
      // Leaving GAP also requires the ack to have dropped, so one long ack
      // cannot retire the next IPI as well.
      ST_GAP: begin
        if (gap_q != '0)
          gap_d = gap_q - GAP_W'(1);
        else if (!bus.ipi_interrupt_ack)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      int_q    <= 1'b0;
      reason_q <= '0;
      issuer_q <= '0;
      gap_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      int_q    <= int_d;
      reason_q <= reason_d;
      issuer_q <= issuer_d;
      gap_q    <= gap_d;
      drop_q   <= drop_d;
    end
  end
endmodule

// File: tb/tb_ipi_delivery_scheduler.sv
// Bench for ipi_delivery_scheduler: directed vectors, expected deliveries
// queued by the driver and checked by an independent monitor.
module tb_ipi_delivery_scheduler;
  import ipi_delivery_scheduler_pkg::*;

  localparam int DEPTH      = 4;
  localparam int MIN_GAP    = 1;
  localparam int DROP_CTR_W = 8;
  localparam int W          = $bits(ipi_entry_t);
  localparam int MY_CORE    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_id_t                  core_id;
  logic [$clog2(DEPTH):0]    pending_count;
  logic [DROP_CTR_W-1:0]     drop_count;
  ipi_state_e                debug_state;

  ipi_delivery_scheduler_if bus();

  ipi_delivery_scheduler #(
    .DEPTH(DEPTH), .MIN_GAP(MIN_GAP), .DROP_CTR_W(DROP_CTR_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .core_id       (core_id),
    .bus           (bus),
    .pending_count (pending_count),
    .drop_count    (drop_count),
    .debug_state   (debug_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one packet for one cycle (rx_issue left high so calls chain
  // back-to-back). exp_push says whether it should land in the queue.
  task automatic drive(input logic valid, input ring_packet_kind_t kind,
                       input int dest_idx, input core_id_t sender,
                       input logic [31:0] reason, input logic exp_push);
    ring_packet p;
    ipi_entry_t e;
    p             = '0;
    p.valid       = valid;
    p.kind        = kind;
    p.sender_id   = sender;
    p.dest_vector = NUM_CORES'(1) << dest_idx;
    p.ipi_reason  = reason;
    bus.rx_issue  = 1'b1;
    bus.rx_packet = p;
    if (exp_push) begin
      e.sender = sender;
      e.reason = reason;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic rx_idle();
    bus.rx_issue  = 1'b0;
    bus.rx_packet = '0;
  endtask

  // Waits (bounded) for the interrupt, then holds ack for 'hold' cycles,
  // checking the interrupt is low on each of those cycles.
  task automatic ack_next(input int hold);
    int t;
    t = 0;
    while (!bus.ipi_interrupt_out && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("int_wait", {63'd0, bus.ipi_interrupt_out}, 64'd1);
    if (bus.ipi_interrupt_out) begin
      bus.ipi_interrupt_ack = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("int_low_during_ack", {63'd0, bus.ipi_interrupt_out}, 64'd0);
      end
      bus.ipi_interrupt_ack = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic       prev;
    logic       had_prior;
    int         low_run;
    ipi_entry_t e;
    prev = 1'b0; had_prior = 1'b0; low_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0; had_prior = 1'b0; low_run = 0;
      end else begin
        if (bus.ipi_interrupt_out && !prev) begin
          if (had_prior)
            chk("gap_low_cycles_ok", {63'd0, (low_run >= MIN_GAP + 1)}, 64'd1);
          if (exp_q.size() == 0) begin
            chk("unexpected_delivery", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("issuer", 64'(bus.ipi_issuer_out), 64'(e.sender));
            chk("reason", 64'(bus.ipi_reason_out), 64'(e.reason));
          end
          had_prior = 1'b1;
          low_run   = 0;
        end else if (!bus.ipi_interrupt_out) begin
          low_run++;
        end
        prev = bus.ipi_interrupt_out;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset                 = 1'b1;
    core_id               = core_id_t'(MY_CORE);
    bus.rx_issue          = 1'b0;
    bus.rx_packet         = '0;
    bus.ipi_interrupt_ack = 1'b0;
    cyc(2);
    chk("rst_int",     {63'd0, bus.ipi_interrupt_out}, 64'd0);
    chk("rst_reason",  64'(bus.ipi_reason_out), 64'd0);
    chk("rst_issuer",  64'(bus.ipi_issuer_out), 64'd0);
    chk("rst_pending", 64'(pending_count), 64'd0);
    chk("rst_drop",    64'(drop_count), 64'd0);
    chk("rst_ready",   {63'd0, bus.rx_ready}, 64'd1);
    reset = 1'b0;
    cyc(8);

    // Single IPI: two-cycle latency, cleared by ack.
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd2, 32'hDEAD_BEEF, 1'b1);
    rx_idle();
    chk("t1_pending_after_push", 64'(pending_count), 64'd1);
    chk("t1_int_not_yet",        {63'd0, bus.ipi_interrupt_out}, 64'd0);
    cyc(1);
    chk("t1_int_latency",        {63'd0, bus.ipi_interrupt_out}, 64'd1);
    chk("t1_pending_presented",  64'(pending_count), 64'd0);
    cyc(2);
    ack_next(1);
    chk("t1_pending_end", 64'(pending_count), 64'd0);
    cyc(4);

    // Three back-to-back IPIs, delivered in order.
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd1, 32'h1, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd1, 32'h2, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd1, 32'h3, 1'b1);
    rx_idle();
    chk("t2_pending_peak", 64'(pending_count), 64'd2);
    chk("t2_int_high",     {63'd0, bus.ipi_interrupt_out}, 64'd1);
    for (int i = 0; i < 3; i++) ack_next(1);
    cyc(3);
    chk("t2_pending_end", 64'(pending_count), 64'd0);
    chk("t2_int_end",     {63'd0, bus.ipi_interrupt_out}, 64'd0);

    // Filtered packets: wrong kind, wrong destination, invalid.
    drive(1'b1, RING_PACKET_KIND_MSG, MY_CORE, 3'd4, 32'h50, 1'b0);
    drive(1'b1, RING_PACKET_KIND_IPI, 2,       3'd4, 32'h51, 1'b0);
    drive(1'b0, RING_PACKET_KIND_IPI, MY_CORE, 3'd4, 32'h52, 1'b0);
    rx_idle();
    cyc(4);
    chk("t3_int",     {63'd0, bus.ipi_interrupt_out}, 64'd0);
    chk("t3_pending", 64'(pending_count), 64'd0);
    chk("t3_drop",    64'(drop_count), 64'd0);

    // Long ack retires exactly one IPI.
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd5, 32'hA1, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd6, 32'hA2, 1'b1);
    rx_idle();
    ack_next(5);
    chk("t4_pending_after_long_ack", 64'(pending_count), 64'd1);
    ack_next(1);
    cyc(3);
    chk("t4_pending_end", 64'(pending_count), 64'd0);

    // Fill with no acks, then force one extra packet.
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd1, 32'hB1, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd2, 32'hB2, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd4, 32'hB3, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd5, 32'hB4, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd6, 32'hB5, 1'b1);
    chk("t5_ready_full",   {63'd0, bus.rx_ready}, 64'd0);
    chk("t5_pending_full", 64'(pending_count), 64'd4);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd7, 32'hB6, 1'b0);
    rx_idle();
    chk("t5_drop",         64'(drop_count), 64'd1);
    chk("t5_pending_kept", 64'(pending_count), 64'd4);
    chk("t5_ready_still",  {63'd0, bus.rx_ready}, 64'd0);
    for (int i = 0; i < 5; i++) ack_next(1);
    cyc(3);
    chk("t5_pending_end", 64'(pending_count), 64'd0);
    chk("t5_ready_end",   {63'd0, bus.rx_ready}, 64'd1);
    chk("t5_drop_end",    64'(drop_count), 64'd1);

    // Reset while presenting with two pending.
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd1, 32'hC1, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd2, 32'hC2, 1'b1);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd4, 32'hC3, 1'b1);
    rx_idle();
    chk("t6_int_before",     {63'd0, bus.ipi_interrupt_out}, 64'd1);
    chk("t6_pending_before", 64'(pending_count), 64'd2);
    reset = 1'b1;
    exp_q.delete();
    cyc(1);
    chk("t6_int_after",     {63'd0, bus.ipi_interrupt_out}, 64'd0);
    chk("t6_pending_after", 64'(pending_count), 64'd0);
    chk("t6_reason_after",  64'(bus.ipi_reason_out), 64'd0);
    chk("t6_issuer_after",  64'(bus.ipi_issuer_out), 64'd0);
    chk("t6_drop_after",    64'(drop_count), 64'd0);
    reset = 1'b0;
    cyc(3);
    chk("t6_no_stale_delivery", {63'd0, bus.ipi_interrupt_out}, 64'd0);
    drive(1'b1, RING_PACKET_KIND_IPI, MY_CORE, 3'd7, 32'h0BAD_F00D, 1'b1);
    rx_idle();
    cyc(1);
    chk("t6_new_int", {63'd0, bus.ipi_interrupt_out}, 64'd1);
    ack_next(1);
    cyc(3);

    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
